// File: rtl/iq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : iq_ctrl
// Purpose  : Instruction-queue sequencing controller. Turns fetch/decode
//            handshakes into queue action codes, tracks occupancy and
//            in-flight fetches, drains on flush and drops stale responses.
// Options  : IQ_CTRL_FULL_PASSTHRU_EN - full queue may enqueue while dequeuing
// Revision : 1.0 - initial release
// ============================================================================
module iq_ctrl #(
    parameter int DEPTH           = 6,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fetch_req,
    output logic                         fetch_req_ok,
    input  logic                         fetch_valid,
    input  logic [31:0]                  fetch_inst,
    output logic                         fetch_ready,
    output logic                         deq_valid,
    output logic [31:0]                  deq_inst,
    input  logic                         deq_ready,
    input  logic                         flush,
    output logic                         draining,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [1:0]                   q_action,
    output logic [31:0]                  q_inst_in,
    input  logic [31:0]                  q_inst_out,
    input  logic                         q_empty,
    input  logic                         q_full
);

    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam int c_OUT_W = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_OUT_W-1:0] c_OUT_ONE = c_OUT_W'(1);
    localparam logic [c_OUT_W-1:0] c_OUT_MAX = c_OUT_W'(MAX_OUTSTANDING);

    localparam logic [0:0] c_RUN   = 1'b0;
    localparam logic [0:0] c_DRAIN = 1'b1;

    logic [0:0]         r_state;
    logic [c_CNT_W-1:0] r_count;
    logic [c_OUT_W-1:0] r_outstanding;
    logic [c_OUT_W-1:0] r_discard;

    logic               w_discarding;
    logic               w_deq_valid;
    logic               w_deq;
    logic               w_enq;
    logic               w_drain_deq;
    logic               w_fetch_ready;
    logic               w_resp;
    logic [c_OUT_W-1:0] w_out_next;

    always_comb begin
        w_discarding = (r_discard != '0);
        w_deq_valid  = rst && !flush && (r_state == c_RUN) && !q_empty;
        w_deq        = w_deq_valid && deq_ready;
        w_drain_deq  = rst && !flush && (r_state == c_DRAIN);

        // Stale responses are always accepted so the fetch unit never stalls on them
        if (!rst)
            w_fetch_ready = 1'b0;
        else if (flush || w_discarding)
            w_fetch_ready = 1'b1;
        else if (r_state == c_DRAIN)
            w_fetch_ready = 1'b0;
        else
`ifdef IQ_CTRL_FULL_PASSTHRU_EN
            w_fetch_ready = !q_full || w_deq;
`else
            w_fetch_ready = !q_full;
`endif

        w_enq  = rst && !flush && (r_state == c_RUN) && fetch_valid &&
                 w_fetch_ready && !w_discarding;
        w_resp = fetch_valid && w_fetch_ready;

        w_out_next = r_outstanding;
        if (fetch_req && !w_resp && (r_outstanding != c_OUT_MAX))
            w_out_next = r_outstanding + c_OUT_ONE;
        else if (!fetch_req && w_resp && (r_outstanding != '0))
            w_out_next = r_outstanding - c_OUT_ONE;
    end

    assign q_action     = {w_deq || w_drain_deq, w_enq};
    assign q_inst_in    = fetch_inst;
    assign deq_valid    = w_deq_valid;
    assign deq_inst     = q_inst_out;
    assign fetch_ready  = w_fetch_ready;
    assign draining     = rst && (r_state == c_DRAIN);
    assign fetch_req_ok = rst && (r_state == c_RUN) && (r_outstanding < c_OUT_MAX);
    assign count        = r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= c_RUN;
            r_count       <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (flush) begin
                // Everything still in flight after this edge belongs to the squashed path
                r_discard <= w_out_next;
                r_state   <= (r_count != '0) ? c_DRAIN : c_RUN;
            end else begin
                if (w_discarding && w_resp)
                    r_discard <= r_discard - c_OUT_ONE;
                if (r_state == c_DRAIN) begin
                    if (r_count != '0)
                        r_count <= r_count - c_CNT_ONE;
                    if (r_count <= c_CNT_ONE)
                        r_state <= c_RUN;
                end else begin
                    case ({w_deq, w_enq})
                        2'b01:   r_count <= r_count + c_CNT_ONE;
                        2'b10:   r_count <= r_count - c_CNT_ONE;
                        default: r_count <= r_count;
                    endcase
                end
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst) begin
            assert ((r_count == '0) == q_empty);
            assert ((r_count == c_CNT_W'(DEPTH)) == q_full);
            assert (!(q_action[1] && q_empty));
`ifdef IQ_CTRL_FULL_PASSTHRU_EN
            assert (!(q_action == 2'b01 && q_full));
`else
            assert (!(q_action[0] && q_full));
`endif
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_iq_ctrl.sv
`default_nettype none
// Bench for iq_ctrl: directed vector table, hand-written flush/credit/full
// sequences and a randomized run, all cross-checked by a behavioural model.
module tb_iq_ctrl;

    localparam int DEPTH = 6;
    localparam int MAXO  = 4;
`ifdef IQ_CTRL_FULL_PASSTHRU_EN
    localparam bit PASS = 1'b1;
`else
    localparam bit PASS = 1'b0;
`endif

    logic        clk, rst, fetch_req, fetch_req_ok, fetch_valid, fetch_ready;
    logic        deq_valid, deq_ready, flush, draining, q_empty, q_full;
    logic [31:0] fetch_inst, deq_inst, q_inst_in, q_inst_out;
    logic [2:0]  count;
    logic [1:0]  q_action;

    iq_ctrl #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_req_ok(fetch_req_ok),
        .fetch_valid(fetch_valid), .fetch_inst(fetch_inst), .fetch_ready(fetch_ready),
        .deq_valid(deq_valid), .deq_inst(deq_inst), .deq_ready(deq_ready),
        .flush(flush), .draining(draining), .count(count), .q_action(q_action),
        .q_inst_in(q_inst_in), .q_inst_out(q_inst_out), .q_empty(q_empty), .q_full(q_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment instruction queue, driven only by the DUT's action code
    logic [31:0] mem [0:DEPTH-1];
    int          q_head, q_n;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_head <= 0;
            q_n    <= 0;
        end else begin
            if (q_action[0]) mem[(q_head + q_n) % DEPTH] <= q_inst_in;
            case (q_action)
                2'b01:   q_n <= (q_n < DEPTH) ? q_n + 1 : q_n;
                2'b10:   begin q_n <= (q_n > 0) ? q_n - 1 : 0; q_head <= (q_head + 1) % DEPTH; end
                2'b11:   q_head <= (q_head + 1) % DEPTH;
                default: q_n <= q_n;
            endcase
        end
    end
    assign q_inst_out = mem[q_head];
    assign q_empty    = (q_n == 0);
    assign q_full     = (q_n == DEPTH);

    int n_vec = 0, n_miss = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Behavioural reference: occupancy as a list of instructions, plus counters
    logic [31:0] mq [$];
    int  m_out, m_disc;
    bit  m_drain;
    bit  n_rst, n_enq, n_deq, n_drain;
    int  n_out, n_disc;
    logic [31:0] n_inst;

    task automatic model_check();
        bit e_fr, e_dv, e_ok, e_dr, enq, deq;
        int t;
        e_fr = 0; e_dv = 0; e_ok = 0; e_dr = 0; enq = 0; deq = 0;
        n_rst = !rst;
        if (rst) begin
            e_ok = !m_drain && (m_out < MAXO);
            e_dr = m_drain;
            if (flush) begin
                e_fr = 1;
            end else if (m_drain) begin
                e_fr = (m_disc > 0);
                deq  = 1;
            end else begin
                e_dv = (mq.size() > 0);
                deq  = e_dv && deq_ready;
                e_fr = (m_disc > 0) || (mq.size() < DEPTH) || (PASS && deq);
                enq  = fetch_valid && e_fr && (m_disc == 0);
            end
        end
        chk("m.q_action", {30'd0, q_action}, {30'd0, deq, enq});
        chk("m.fetch_ready", {31'd0, fetch_ready}, {31'd0, e_fr});
        chk("m.deq_valid", {31'd0, deq_valid}, {31'd0, e_dv});
        chk("m.fetch_req_ok", {31'd0, fetch_req_ok}, {31'd0, e_ok});
        chk("m.draining", {31'd0, draining}, {31'd0, e_dr});
        chk("m.count", {29'd0, count}, mq.size());
        chk("m.q_inst_in", q_inst_in, fetch_inst);
        if (e_dv) chk("m.deq_inst", deq_inst, mq[0]);
        t = m_out + int'(fetch_req) - int'(fetch_valid && e_fr);
        n_out   = (t < 0) ? 0 : ((t > MAXO) ? MAXO : t);
        n_disc  = flush ? n_out : ((m_disc > 0 && fetch_valid) ? m_disc - 1 : m_disc);
        n_drain = flush ? (mq.size() > 0) : (m_drain && mq.size() > 1);
        n_enq = enq; n_deq = deq; n_inst = fetch_inst;
    endtask

    task automatic model_update();
        if (n_rst) begin
            mq.delete(); m_out = 0; m_disc = 0; m_drain = 0;
        end else begin
            if (n_deq && mq.size() > 0) void'(mq.pop_front());
            if (n_enq) mq.push_back(n_inst);
            m_out = n_out; m_disc = n_disc; m_drain = n_drain;
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic advance();
        model_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input bit r, input bit rq, input bit fv, input bit dr, input bit fl,
                         input logic [31:0] inst);
        rst = r; fetch_req = rq; fetch_valid = fv; deq_ready = dr; flush = fl; fetch_inst = inst;
    endtask

    typedef struct {
        bit          r, fv, dr;
        logic [31:0] inst;
        logic [1:0]  e_act;
        bit          e_fr, e_dv;
        logic [31:0] e_di;
        int          e_cnt;
    } vec_t;
    vec_t tbl [$];

    task automatic add(input bit r, input bit fv, input bit dr, input logic [31:0] inst,
                       input logic [1:0] act, input bit fr, input bit dv,
                       input logic [31:0] di, input int cnt);
        vec_t v;
        v.r = r; v.fv = fv; v.dr = dr; v.inst = inst; v.e_act = act;
        v.e_fr = fr; v.e_dv = dv; v.e_di = di; v.e_cnt = cnt;
        tbl.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] fill [0:5];
        fill[0] = 32'h11111111; fill[1] = 32'h22222222; fill[2] = 32'h33333333;
        fill[3] = 32'h44444444; fill[4] = 32'h55555555; fill[5] = 32'h66666666;
        drive(0, 0, 0, 0, 0, 32'h0);
        m_out = 0; m_disc = 0; m_drain = 0;

        for (int i = 0; i < 4; i++) add(0, 1, 1, 32'haaaabbbb, 2'b00, 0, 0, 0, 0);
        add(1, 1, 1, 32'haaaabbbb, 2'b01, 1, 0, 0, 0);
        add(1, 0, 1, 32'h0, 2'b10, 1, 1, 32'haaaabbbb, 1);
        for (int i = 0; i < 6; i++) add(1, 1, 0, fill[i], 2'b01, 1, i != 0, fill[0], i);
        add(1, 1, 0, 32'h77777777, 2'b00, 0, 1, fill[0], 6);
        for (int i = 0; i < 3; i++) add(1, 0, 1, 32'h0, 2'b10, (i == 0) ? PASS : 1'b1, 1, fill[i], 6 - i);
        add(1, 1, 1, 32'hdeaddead, 2'b11, 1, 1, fill[3], 3);
        add(1, 0, 1, 32'h0, 2'b10, 1, 1, fill[4], 3);
        add(1, 0, 1, 32'h0, 2'b10, 1, 1, fill[5], 2);
        add(1, 0, 1, 32'h0, 2'b10, 1, 1, 32'hdeaddead, 1);
        add(1, 0, 1, 32'h0, 2'b00, 1, 0, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].r, 0, tbl[i].fv, tbl[i].dr, 0, tbl[i].inst);
            settle();
            chk($sformatf("t%0d.q_action", i), {30'd0, q_action}, {30'd0, tbl[i].e_act});
            chk($sformatf("t%0d.fetch_ready", i), {31'd0, fetch_ready}, {31'd0, tbl[i].e_fr});
            chk($sformatf("t%0d.deq_valid", i), {31'd0, deq_valid}, {31'd0, tbl[i].e_dv});
            chk($sformatf("t%0d.count", i), {29'd0, count}, tbl[i].e_cnt);
            if (tbl[i].e_dv) chk($sformatf("t%0d.deq_inst", i), deq_inst, tbl[i].e_di);
            advance();
        end

        // Flush with 4 queued entries and 2 requests in flight
        for (int i = 0; i < 4; i++) begin drive(1, 0, 1, 0, 0, 32'hc0de0000 + i); settle(); advance(); end
        for (int i = 0; i < 2; i++) begin drive(1, 1, 0, 0, 0, 32'h0); settle(); advance(); end
        drive(1, 0, 0, 0, 1, 32'h0);
        settle();
        chk("flush.q_action", {30'd0, q_action}, 32'd0);
        chk("flush.deq_valid", {31'd0, deq_valid}, 32'd0);
        chk("flush.count", {29'd0, count}, 32'd4);
        advance();
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, k < 2, 1, 0, 32'hbad00000 + k);
            settle();
            chk("drain.q_action", {30'd0, q_action}, 32'd2);
            chk("drain.deq_valid", {31'd0, deq_valid}, 32'd0);
            chk("drain.draining", {31'd0, draining}, 32'd1);
            chk("drain.fetch_req_ok", {31'd0, fetch_req_ok}, 32'd0);
            chk("drain.fetch_ready", {31'd0, fetch_ready}, {31'd0, k < 2});
            chk("drain.count", {29'd0, count}, 4 - k);
            advance();
        end
        drive(1, 0, 0, 0, 0, 32'h0);
        settle();
        chk("resume.draining", {31'd0, draining}, 32'd0);
        chk("resume.count", {29'd0, count}, 32'd0);
        chk("resume.fetch_req_ok", {31'd0, fetch_req_ok}, 32'd1);
        advance();

        // Outstanding-request cap
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 0, 0, 32'h0);
            settle();
            chk("cap.ok_before", {31'd0, fetch_req_ok}, 32'd1);
            advance();
        end
        drive(1, 0, 0, 0, 0, 32'h0);
        settle();
        chk("cap.ok_at_max", {31'd0, fetch_req_ok}, 32'd0);
        advance();
        drive(1, 0, 1, 0, 0, 32'h5a5a5a5a);
        settle();
        chk("cap.resp_enq", {30'd0, q_action}, 32'd1);
        advance();
        drive(1, 0, 0, 0, 0, 32'h0);
        settle();
        chk("cap.ok_after", {31'd0, fetch_req_ok}, 32'd1);
        advance();

        // Full queue with simultaneous dequeue and response
        for (int i = 0; i < 5; i++) begin drive(1, 0, 1, 0, 0, 32'hf0000000 + i); settle(); advance(); end
        drive(1, 0, 1, 1, 0, 32'h77777777);
        settle();
        chk("full.q_action", {30'd0, q_action}, PASS ? 32'd3 : 32'd2);
        chk("full.fetch_ready", {31'd0, fetch_ready}, {31'd0, PASS});
        advance();
        drive(1, 0, 0, 1, 0, 32'h0);
        settle();
        chk("full.count", {29'd0, count}, PASS ? 32'd6 : 32'd5);
        advance();
        for (int i = 0; i < 6; i++) begin settle(); advance(); end

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            drive(1, (!m_drain && m_out < MAXO) && ($urandom_range(0, 1) == 1),
                  (m_out > 0) && ($urandom_range(0, 2) != 0),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0, $urandom);
            settle();
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/iq_ctrl.md
Name: iq_ctrl

Overview:
- Sequencing controller for the instruction queue (the queue takes a 2-bit action code, inst_in/inst_out, and produces empty/full).
- Sits between the fetch unit (producer) and decode/dispatch (consumer), and converts their valid/ready handshakes into queue action codes.
- Tracks queue occupancy and in-flight fetch requests.
- On a branch-redirect flush, drains the queue and discards stale fetch responses.

Parameters:
- DEPTH, 6, queue capacity in entries (must match the instruction_q instance).
- MAX_OUTSTANDING, 4, max fetch requests in flight without a response.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- fetch_req  in  1  fetch issued an I-cache request this cycle.
- fetch_req_ok  out  1  fetch may issue a request this cycle.
- fetch_valid  in  1  fetch response valid.
- fetch_inst  in  32  fetched instruction.
- fetch_ready  out  1  response accepted (enqueued or discarded).
- deq_valid  out  1  queue front valid to decode.
- deq_inst  out  32  queue front instruction.
- deq_ready  in  1  decode accepts the front entry.
- flush  in  1  redirect; squash all queued and in-flight instructions.
- draining  out  1  controller is in DRAIN.
- count  out  $clog2(DEPTH+1)  entries in the queue.
- q_action  out  2  queue action: 00 none, 01 enqueue, 10 dequeue, 11 both.
- q_inst_in  out  32  equals fetch_inst.
- q_inst_out  in  32  queue front (combinational).
- q_empty  in  1  queue empty.
- q_full  in  1  queue full.

Behaviour:
- Reset (rst low, async):
  - Registers: state=RUN, count=0, outstanding=0, discard_cnt=0.
  - Outputs forced while rst low: q_action=00, deq_valid=0, fetch_ready=0, fetch_req_ok=0, draining=0.
- States: RUN, DRAIN.
- RUN, no flush:
  - enq = fetch_valid && fetch_ready && discard_cnt==0.
  - fetch_ready = !q_full when discard_cnt==0; fetch_ready = 1 when discard_cnt!=0 (response dropped, discard_cnt decrements).
  - deq_valid = !q_empty; deq_inst = q_inst_out; deq = deq_valid && deq_ready.
  - q_action = {deq, enq}.
  - count += enq - deq each cycle; q_action 11 leaves count unchanged.
- Empty + fetch_valid + deq_ready: deq_valid=0, so q_action=01 only (no bypass).
- Flush cycle (any state), highest priority:
  - q_action=00, deq_valid=0; the fetch_valid in that cycle is dropped (fetch_ready=1).
  - discard_cnt <= outstanding + fetch_req - fetch_valid.
  - Next state DRAIN if count!=0, else RUN.
- DRAIN:
  - q_action=10 every cycle, count decrements; deq_valid=0; draining=1; fetch_req_ok=0.
  - When count==1, dequeue and return to RUN next cycle.
  - Stale responses arriving in DRAIN are dropped (fetch_ready=1 iff discard_cnt!=0).
  - A flush in DRAIN recaptures discard_cnt and stays in DRAIN.
- Outstanding counter:
  - outstanding += fetch_req - fetch_valid, saturating in [0, MAX_OUTSTANDING].
  - fetch_req_ok = (state==RUN) && (outstanding < MAX_OUTSTANDING).
  - Responses that are discarded still decrement outstanding.
- Invariants (assert in sim):
  - count==0 iff q_empty; count==DEPTH iff q_full.
  - Never drive enqueue when q_full, except under the optional feature.
  - Never drive dequeue when q_empty.
- Latency: an enqueued instruction is visible on deq_inst the cycle after its enqueue edge.

Optional Feature:
- Macro: IQ_CTRL_FULL_PASSTHRU_EN.
- Defined: in RUN, fetch_ready = !q_full || (deq_valid && deq_ready), so a full queue accepts an enqueue in the same cycle it dequeues (action 11 at full); count stays DEPTH.
- Undefined: fetch_ready = !q_full; a full queue accepts a dequeue only (action 10).

Test Plan:
- Reset: rst low 4 cycles with fetch_valid=1, deq_ready=1 -> q_action=00, fetch_ready=0, deq_valid=0, count=0; after release, first push of 0xaaaabbbb -> q_action=01, count=1.
- Fill: deq_ready=0, push 0x11111111..0x66666666 -> count=6, q_full, fetch_ready=0; 7th fetch_valid holds with q_action=00; deq_inst=0x11111111.
- Simultaneous: count=3, fetch_valid=1 (0xdeaddead), deq_ready=1 -> q_action=11, count stays 3, front advances in order.
- Flush: count=4, outstanding=2 -> flush cycle q_action=00, then 4 DRAIN cycles with q_action=10 and deq_valid=0; next 2 fetch_valid dropped (no 01 issued); RUN resumes with count=0 and fetch_req_ok=1.
- Outstanding cap: 4 fetch_req with no response -> fetch_req_ok=0; one fetch_valid -> fetch_req_ok=1 next cycle.
- Passthru (macro defined): full queue, deq_ready=1, fetch_valid=1 -> q_action=11, count=6; macro undefined -> q_action=10, count=5.
